// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder arbiter.
package adder_share_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNTW  = 16;

    // ceil(log2(n)), never below 1 so a 1-bit id always exists
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/adder_share_arb_add.sv
// Generated adder: WIDTH-bit operands, WIDTH+1-bit sum, no carry-in.
module adder_share_arb_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a
// single-entry valid/ready result register and an accepted-op counter.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = clog2_min1(NREQ),
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH:0]        res_sum,
    output logic [IDW-1:0]        res_id,
    output logic [CNTW-1:0]       ops_cnt
);

    localparam logic [IDW:0]   NREQ_E = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    state_e             state_q, state_d;
    logic [WIDTH:0]     res_sum_q, res_sum_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [CNTW-1:0]    ops_cnt_q, ops_cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [WIDTH:0]     sum;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW:0]       idx_ext;
    logic               can_accept;
    logic               xfer;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // Round-robin search: first valid index at or after ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_ext   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_ext = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_ext >= NREQ_E) idx_ext = idx_ext - NREQ_E;
            if (!gnt_found && req_valid[idx_ext[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_ext[IDW-1:0];
            end
        end
    end

    // Result register can take new data when empty or being drained this cycle
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || res_ready;
        xfer       = gnt_found && can_accept;
        req_ready  = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
        a_sel = a_arr[gnt_idx];
        b_sel = b_arr[gnt_idx];
    end

    adder_share_arb_add #(.WIDTH(WIDTH)) u_add (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    // Next-state: load sum/id on transfer, advance pointer past the winner
    always_comb begin
        state_d   = state_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
        ops_cnt_d = ops_cnt_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            state_d   = ST_FULL;
            res_sum_d = sum;
            res_id_d  = gnt_idx;
            ops_cnt_d = ops_cnt_q + CNTW'(1);
            ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + IDW'(1);
        end else if (can_accept) begin
            state_d = ST_EMPTY;
        end
    end

    // Result FSM and registers; reset drops any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            res_sum_q <= '0;
            res_id_q  <= '0;
            ops_cnt_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
            ops_cnt_q <= ops_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb against a queue-free behavioural model.
module tb_adder_share_arb;

    localparam int W  = 35;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [N-1:0]      req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W:0]        res_sum;
    logic [IW-1:0]     res_id;
    logic [CW-1:0]     ops_cnt;

    adder_share_arb #(.WIDTH(W), .NREQ(N), .IDW(IW), .CNTW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] ta [N];
    logic [W-1:0] tb [N];

    // reference model state
    logic          m_valid;
    logic [W:0]    m_sum;
    logic [IW-1:0] m_id;
    logic [CW-1:0] m_cnt;
    int            m_ptr;

    logic [N-1:0] gr, er;

    function automatic int model_pick();
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        logic [N-1:0] r;
        g = model_pick();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_clock();
        int g;
        if (rst) begin
            m_valid = 1'b0; m_sum = '0; m_id = '0; m_cnt = '0; m_ptr = 0;
            return;
        end
        g = model_pick();
        if (g >= 0) begin
            m_sum   = {1'b0, ta[g]} + {1'b0, tb[g]};
            m_id    = IW'(g);
            m_ptr   = (g + 1) % N;
            m_cnt   = m_cnt + 1'b1;
            m_valid = 1'b1;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy);
        req_valid = v;
        res_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ta[i];
            req_b[i*W +: W] = tb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            ta[i] = W'({$urandom, $urandom});
            tb[i] = W'({$urandom, $urandom});
        end
    endtask

    // advance one clock: sample ready, step model, sample outputs after edge
    task automatic cycle(output logic [N-1:0] got_rdy, output logic [N-1:0] exp_rdy);
        #1;
        got_rdy = req_ready;
        exp_rdy = model_ready();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive('0, 1'b0);
        cycle(gr, er);
        cycle(gr, er);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rand_ops();
        drive('0, 1'b0);
        cycle(gr, er);
        cycle(gr, er);
        n_chk++;
        if ({res_valid, res_sum, res_id, ops_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b sum=%h id=%0d cnt=%0d exp all zero",
                     res_valid, res_sum, res_id, ops_cnt);
        end
        rst = 1'b0;
        cycle(gr, er);
        n_chk++;
        if (gr !== 4'b0000 || res_valid !== 1'b0 || ops_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle got rdy=%b v=%b cnt=%0d exp 0000/0/0", gr, res_valid, ops_cnt);
        end
    endtask

    task automatic test_single();
        rand_ops();
        ta[0] = W'(8'hFF);
        tb[0] = W'(8'h01);
        drive(4'b0001, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (gr !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=0001", gr);
        end
        n_chk++;
        if (res_valid !== 1'b1 || res_sum !== (W+1)'(9'h100) || res_id !== 2'd0 || ops_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_result got v=%b sum=%h id=%0d cnt=%0d exp 1/100/0/1",
                     res_valid, res_sum, res_id, ops_cnt);
        end
        drive(4'b0000, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (res_valid !== 1'b0 || ops_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_drain got v=%b cnt=%0d exp 0/1", res_valid, ops_cnt);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            drive(4'b1111, 1'b1);
            cycle(gr, er);
            n_chk++;
            if (gr !== er) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, gr, er);
            end
            n_chk++;
            if (res_valid !== 1'b1 || res_id !== IW'(i % N) || res_sum !== m_sum) begin
                n_fail++;
                $display("FAIL b2b_result[%0d] got v=%b id=%0d sum=%h exp 1/%0d/%h",
                         i, res_valid, res_id, res_sum, i % N, m_sum);
            end
        end
        n_chk++;
        if (ops_cnt !== 8'd8) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=8", ops_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [W:0]    s_sum;
        logic [IW-1:0] s_id;
        rand_ops();
        drive(4'b1111, 1'b0);
        cycle(gr, er);
        s_sum = res_sum;
        s_id  = res_id;
        n_chk++;
        if (res_valid !== 1'b1 || res_sum !== m_sum || res_id !== m_id) begin
            n_fail++;
            $display("FAIL bp_fill got v=%b id=%0d sum=%h exp 1/%0d/%h", res_valid, res_id, res_sum, m_id, m_sum);
        end
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            drive(4'b1111, 1'b0);
            cycle(gr, er);
            n_chk++;
            if (gr !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready[%0d] got=%b exp=0000", i, gr);
            end
            n_chk++;
            if (res_valid !== 1'b1 || res_sum !== s_sum || res_id !== s_id) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%h exp 1/%0d/%h",
                         i, res_valid, res_id, res_sum, s_id, s_sum);
            end
        end
        rand_ops();
        drive(4'b1111, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (gr !== er || gr === 4'b0000) begin
            n_fail++;
            $display("FAIL bp_release_ready got=%b exp=%b", gr, er);
        end
        n_chk++;
        if (res_valid !== 1'b1 || res_sum !== m_sum || res_id !== m_id || ops_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL bp_release_result got id=%0d sum=%h cnt=%0d exp %0d/%h/%0d",
                     res_id, res_sum, ops_cnt, m_id, m_sum, m_cnt);
        end
        drive(4'b0000, 1'b1);
        cycle(gr, er);
    endtask

    task automatic test_wrap();
        int guard;
        pulse_reset();
        rand_ops();
        drive(4'b0100, 1'b1);
        cycle(gr, er);
        rand_ops();
        drive(4'b1010, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (gr !== 4'b1000 || res_id !== 2'd3 || res_sum !== ({1'b0, ta[3]} + {1'b0, tb[3]})) begin
            n_fail++;
            $display("FAIL wrap_first got rdy=%b id=%0d exp 1000/3", gr, res_id);
        end
        rand_ops();
        drive(4'b1010, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (gr !== 4'b0010 || res_id !== 2'd1 || res_sum !== ({1'b0, ta[1]} + {1'b0, tb[1]})) begin
            n_fail++;
            $display("FAIL wrap_second got rdy=%b id=%0d exp 0010/1", gr, res_id);
        end
        guard = 0;
        while (m_cnt != 8'hFF && guard < 300) begin
            rand_ops();
            drive(4'b1111, 1'b1);
            cycle(gr, er);
            guard++;
        end
        n_chk++;
        if (ops_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL cnt_preWrap got=%0d exp=255", ops_cnt);
        end
        rand_ops();
        drive(4'b1111, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (ops_cnt !== 8'h00 || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_wrap got cnt=%0d v=%b exp 0/1", ops_cnt, res_valid);
        end
        drive(4'b0000, 1'b1);
        cycle(gr, er);
    endtask

    task automatic test_reset_mid();
        rand_ops();
        drive(4'b0110, 1'b0);
        cycle(gr, er);
        n_chk++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fill got v=%b exp 1", res_valid);
        end
        rst = 1'b1;
        drive(4'b1111, 1'b1);
        cycle(gr, er);
        rst = 1'b0;
        n_chk++;
        if (res_valid !== 1'b0 || ops_cnt !== 8'd0 || res_sum !== '0 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear got v=%b cnt=%0d sum=%h id=%0d exp 0/0/0/0",
                     res_valid, ops_cnt, res_sum, res_id);
        end
        rand_ops();
        drive(4'b1111, 1'b1);
        cycle(gr, er);
        n_chk++;
        if (gr !== 4'b0001 || res_id !== 2'd0 || ops_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rstmid_ptr got rdy=%b id=%0d cnt=%0d exp 0001/0/1", gr, res_id, ops_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rand_ops();
            drive(4'($urandom), ($urandom_range(0, 9) < 7));
            cycle(gr, er);
            n_chk++;
            if (gr !== er) begin
                n_fail++;
                $display("FAIL rand_ready[%0d] got=%b exp=%b", i, gr, er);
            end
            n_chk++;
            if (res_valid !== m_valid || res_sum !== m_sum || res_id !== m_id || ops_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_result[%0d] got v=%b id=%0d sum=%h cnt=%0d exp %b/%0d/%h/%0d",
                         i, res_valid, res_id, res_sum, ops_cnt, m_valid, m_id, m_sum, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        m_valid = 1'b0; m_sum = '0; m_id = '0; m_cnt = '0; m_ptr = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
